// File: rtl/clk_seq_pkg.sv
// Shared mode encodings and display constants for the clock-enable divider sequencer
// and the display blocks that reuse its LFSR.
package clk_seq_pkg;

  typedef enum logic [1:0] {
    MODE_INIT   = 2'b00,
    MODE_ALL_ON = 2'b01,
    MODE_DIV_A  = 2'b10,
    MODE_DIV_B  = 2'b11
  } mode_e;

  localparam logic [2:0] LFSR_SEED  = 3'b001;
  localparam logic [2:0] LED_ALL_ON = 3'b011;

  function automatic logic is_dividing(input mode_e m);
    return (m == MODE_DIV_A) || (m == MODE_DIV_B);
  endfunction

endpackage

// File: rtl/lfsr3.sv
// 3-bit maximal-length LFSR (x^3+x^2+1), advanced once per step_en cycle.
module lfsr3
  import clk_seq_pkg::*;
(
  input  logic       clock_in,
  input  logic       reset,
  input  logic       step_en,
  output logic [2:0] value
);

  // NOTE: reset is sampled on the clock edge (synchronous) and all state uses <=
  // so every register sees the values from before the edge.
  always_ff @(posedge clock_in) begin
    if (!reset) begin
      value <= LFSR_SEED;
    end else if (step_en) begin
      value <= {value[1:0], value[2] ^ value[1]};
    end
  end

endmodule

// File: rtl/clk_div_sequencer.sv
// Mode sequencer driving a programmable clock-enable divider; ratio changes wait for
// a period boundary so div_out never glitches or produces runt pulses.
module clk_div_sequencer
  import clk_seq_pkg::*;
#(
  parameter int DIV_W = 4,
  parameter int DIV_A = 2,
  parameter int DIV_B = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       advance,
  output logic [1:0] mode,
  output logic       div_out,
  output logic       step_en,
  output logic       pending,
  output logic [2:0] led
);

  localparam int DIV_MAX = 2 ** DIV_W;

  if (DIV_A < 2 || DIV_A > DIV_MAX || DIV_B < 2 || DIV_B > DIV_MAX) begin : g_bad_ratio
    $error("clk_div_sequencer: DIV_A/DIV_B must lie in [2, 2**DIV_W]");
  end

  localparam logic [DIV_W:0] RATIO_A = (DIV_W + 1)'(DIV_A);
  localparam logic [DIV_W:0] RATIO_B = (DIV_W + 1)'(DIV_B);

  function automatic logic [DIV_W:0] ratio_of(input mode_e m);
    return (m == MODE_DIV_B) ? RATIO_B : RATIO_A;
  endfunction

  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             step_q, step_d;
  logic             pending_q, pending_d;
  logic             accept;
  logic             boundary;
  logic [2:0]       lfsr_value;

  assign accept   = advance && !pending_q;
  assign boundary = is_dividing(mode_q) && ({1'b0, cnt_q} == ratio_of(mode_q) - 1'b1);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    mode_d    = mode_q;
    pending_d = pending_q;
    cnt_d     = '0;
    div_d     = 1'b0;
    step_d    = 1'b0;

    case (mode_q)
      MODE_INIT:   if (accept) mode_d = MODE_ALL_ON;
      MODE_ALL_ON: if (accept) mode_d = MODE_DIV_A;
      MODE_DIV_A, MODE_DIV_B: begin
        // A ratio switch only ever lands on the last cycle of the running period.
        if (boundary && (accept || pending_q)) begin
          mode_d    = (mode_q == MODE_DIV_A) ? MODE_DIV_B : MODE_DIV_A;
          pending_d = 1'b0;
        end else if (accept) begin
          pending_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (is_dividing(mode_d)) begin
      if (!is_dividing(mode_q) || boundary) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      div_d  = ({1'b0, cnt_d} < (ratio_of(mode_d) >> 1));
      step_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset) begin
      mode_q    <= MODE_INIT;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      step_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      step_q    <= step_d;
      pending_q <= pending_d;
    end
  end

  lfsr3 u_lfsr (
    .clock_in (clock_in),
    .reset    (reset),
    .step_en  (step_q),
    .value    (lfsr_value)
  );

  always_comb begin
    case (mode_q)
      MODE_INIT:   led = 3'b000;
      MODE_ALL_ON: led = LED_ALL_ON;
      default:     led = lfsr_value;
    endcase
  end

  assign mode    = mode_q;
  assign div_out = div_q;
  assign step_en = step_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Scoreboard bench for clk_div_sequencer: directed per-cycle vectors queue their expected
// outputs, and a monitor compares them after each clock edge.
module tb_clk_div_sequencer;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b0;
  logic       advance  = 1'b0;
  logic [1:0] mode;
  logic       div_out;
  logic       step_en;
  logic       pending;
  logic [2:0] led;

  clk_div_sequencer #(.DIV_W(4), .DIV_A(2), .DIV_B(3)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .advance  (advance),
    .mode     (mode),
    .div_out  (div_out),
    .step_en  (step_en),
    .pending  (pending),
    .led      (led)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [1:0] mode;
    logic       div_out;
    logic       step_en;
    logic       pending;
    logic [2:0] led;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Expected LFSR walk from the seed, x^3+x^2+1.
  logic [2:0] lfsr_seq [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
  int         lfsr_idx  = 0;
  logic       prev_step = 1'b0;

  // Drive one cycle's inputs and queue what the outputs must be after that edge.
  task automatic cyc(input logic adv, input logic rstn, input logic [1:0] m,
                     input logic d, input logic s, input logic p, input string name);
    exp_t e;
    if (!rstn) lfsr_idx = 0;
    else if (prev_step) lfsr_idx = (lfsr_idx + 1) % 7;
    prev_step = s;
    e.mode    = m;
    e.div_out = d;
    e.step_en = s;
    e.pending = p;
    e.led     = (m == 2'b00) ? 3'b000 : (m == 2'b01) ? 3'b011 : lfsr_seq[lfsr_idx];
    e.name    = name;
    advance   = adv;
    reset     = rstn;
    sb.push_back(e);
    @(posedge clock_in);
    #1;
    advance = 1'b0;
    reset   = 1'b1;
  endtask

  always @(posedge clock_in) begin
    #2;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if ({mode, div_out, step_en, pending, led} !==
          {e.mode, e.div_out, e.step_en, e.pending, e.led}) begin
        miscompares++;
        $display("FAIL %s @%0t: got mode=%b div=%b step=%b pend=%b led=%b, want mode=%b div=%b step=%b pend=%b led=%b",
                 e.name, $time, mode, div_out, step_en, pending, led,
                 e.mode, e.div_out, e.step_en, e.pending, e.led);
      end
    end
  end

  initial begin
    cyc(0, 0, 2'b00, 0, 0, 0, "reset0");
    cyc(0, 0, 2'b00, 0, 0, 0, "reset1");
    repeat (19) cyc(0, 1, 2'b00, 0, 0, 0, "init_idle");

    cyc(1, 1, 2'b01, 0, 0, 0, "to_all_on");
    repeat (19) cyc(0, 1, 2'b01, 0, 0, 0, "all_on_idle");

    // DIV_A: toggles every cycle, step every 2; LFSR covers its full period here.
    cyc(1, 1, 2'b10, 1, 1, 0, "to_div_a");
    for (int k = 1; k <= 20; k++)
      cyc(0, 1, 2'b10, (k % 2) == 0, (k % 2) == 0, 0, "div_a_run");

    // Advance at cnt==0: one pending cycle, then DIV_B starts at the boundary.
    cyc(1, 1, 2'b10, 0, 0, 1, "adv_cnt0_pending");
    cyc(0, 1, 2'b11, 1, 1, 0, "switch_to_b");
    for (int j = 1; j <= 8; j++)
      cyc(0, 1, 2'b11, (j % 3) == 0, (j % 3) == 0, 0, "div_b_run");

    // Advance on the DIV_B boundary (cnt==2): immediate switch, no pending.
    cyc(1, 1, 2'b10, 1, 1, 0, "adv_boundary_b_to_a");
    cyc(0, 1, 2'b10, 0, 0, 0, "div_a_ph1");
    cyc(1, 1, 2'b11, 1, 1, 0, "adv_boundary_a_to_b");
    cyc(0, 1, 2'b11, 0, 0, 0, "b_ph1");
    cyc(0, 1, 2'b11, 0, 0, 0, "b_ph2");
    cyc(0, 1, 2'b11, 1, 1, 0, "b_ph0");

    // Second advance while pending is dropped: exactly one switch.
    cyc(1, 1, 2'b11, 0, 0, 1, "adv_cnt0_pending_b");
    cyc(1, 1, 2'b11, 0, 0, 1, "adv_ignored");
    cyc(0, 1, 2'b10, 1, 1, 0, "single_switch");
    cyc(0, 1, 2'b10, 0, 0, 0, "a_after_switch_ph1");
    cyc(0, 1, 2'b10, 1, 1, 0, "a_after_switch_ph0");
    cyc(0, 1, 2'b10, 0, 0, 0, "a_after_switch_ph1b");

    // Reset while a DIV_B request is pending.
    cyc(1, 1, 2'b11, 1, 1, 0, "a_to_b_again");
    cyc(1, 1, 2'b11, 0, 0, 1, "pending_before_reset");
    cyc(0, 0, 2'b00, 0, 0, 0, "reset_while_pending");
    cyc(0, 1, 2'b00, 0, 0, 0, "post_reset0");
    cyc(0, 1, 2'b00, 0, 0, 0, "post_reset1");
    cyc(1, 1, 2'b01, 0, 0, 0, "reentry_all_on");
    cyc(1, 1, 2'b10, 1, 1, 0, "reentry_seed");
    cyc(0, 1, 2'b10, 0, 0, 0, "reentry_step");

    for (int w = 0; w < 5 && sb.size() != 0; w++) @(posedge clock_in);
    #5;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d expectations left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
